eth_rx_frame_buf: RTL and testbench

ETH_RX_FRAME_BUF -- requirements
Module: eth_rx_frame_buf

---
 rtl/eth_pkg.sv | 35 +++
 rtl/eth_len_fifo.sv | 54 +++++
 rtl/eth_rx_frame_buf.sv | 252 +++++++++++++++++++++++++
 tb/tb_eth_rx_frame_buf.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/eth_pkg.sv
// ---------------------------------------------------------------------------
// eth_pkg
// Shared constants for the MAC receive frame buffer: Ethernet frame limits,
// write/read FSM state encodings and small helpers used by eth_rx_frame_buf.
// ---------------------------------------------------------------------------
package eth_pkg;

   localparam int FCS_LEN   = 4;
   localparam int MIN_FRAME = 64;
   localparam int MAX_FRAME = 1522;
   localparam int LEN_W     = 11;

   typedef logic [LEN_W-1:0] frame_len_t;

   // Write-side FSM encodings
   localparam logic [1:0] WR_IDLE  = 2'd0;
   localparam logic [1:0] WR_FRAME = 2'd1;
   localparam logic [1:0] WR_DROP  = 2'd2;

   // Read-side FSM encodings
   localparam logic [1:0] RD_IDLE   = 2'd0;
   localparam logic [1:0] RD_PRIME  = 2'd1;
   localparam logic [1:0] RD_STREAM = 2'd2;

   // Frame length (including FCS) inside the legal Ethernet range.
   function automatic logic len_ok(input frame_len_t len);
      return (len >= LEN_W'(MIN_FRAME)) && (len <= LEN_W'(MAX_FRAME));
   endfunction

   // Increment that sticks at all-ones.
   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

endpackage

// File: rtl/eth_len_fifo.sv
// ---------------------------------------------------------------------------
// eth_len_fifo
// Synchronous first-word-fall-through FIFO holding committed-frame lengths.
// Ports:
//   clk_mac, rst_n : clock, synchronous active-low reset
//   push, din      : write request and data (ignored when full)
//   pop            : read request (ignored when empty); dout shows head entry
//   full, empty    : occupancy flags
// Push and pop in the same cycle both take effect.
// ---------------------------------------------------------------------------
module eth_len_fifo #(
   parameter int W       = 11,
   parameter int DEPTH_W = 4
) (
   input  logic         clk_mac,
   input  logic         rst_n,
   input  logic         push,
   input  logic [W-1:0] din,
   input  logic         pop,
   output logic [W-1:0] dout,
   output logic         full,
   output logic         empty
);

   logic [W-1:0]   store [0:(1<<DEPTH_W)-1];
   logic [DEPTH_W:0] wp;
   logic [DEPTH_W:0] rp;
   logic           do_push;
   logic           do_pop;

   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   // Extra pointer MSB distinguishes full from empty when the indices match.
   assign empty = (wp == rp);
   assign full  = (wp[DEPTH_W] != rp[DEPTH_W]) &&
                  (wp[DEPTH_W-1:0] == rp[DEPTH_W-1:0]);
   assign dout  = store[rp[DEPTH_W-1:0]];

   always_ff @(posedge clk_mac) begin
      if (!rst_n) begin
         wp <= '0;
         rp <= '0;
      end else begin
         if (do_push) wp <= wp + 1'b1;
         if (do_pop)  rp <= rp + 1'b1;
      end
   end

   always_ff @(posedge clk_mac) begin
      if (do_push) store[wp[DEPTH_W-1:0]] <= din;
   end

endmodule

// File: rtl/eth_rx_frame_buf.sv
// ---------------------------------------------------------------------------
// eth_rx_frame_buf
// Store-and-forward receive buffer. Bytes from the MAC receiver are written
// speculatively; a frame becomes visible to the reader only when its end
// beat passes the error/length/queue checks. Bad, oversize or overflowing
// frames are rolled back to the last commit point and counted.
// Ports:
//   clk_mac, rst_n                 : clock, synchronous active-low reset
//   rx_vld/sof/eof/err, rx_dat     : receive beats (eof beat carries no data)
//   rx_len                         : running byte count incl. FCS
//   m_vld/m_rdy, m_dat/sof/eof/len : output byte stream, m_len excludes FCS
//   drop_cnt                       : saturating count of discarded frames
//   wr_state_dbg, rd_state_dbg     : current write/read FSM state
//
// Output handshake: a byte transfers on every rising edge where m_vld and
// m_rdy are both 1. Once m_vld is raised, m_vld, m_dat, m_sof, m_eof and
// m_len stay unchanged until that transfer; m_vld never depends on m_rdy.
// ---------------------------------------------------------------------------
module eth_rx_frame_buf
   import eth_pkg::*;
#(
   parameter int ADDR_W       = 12,
   parameter int DESC_DEPTH_W = 4
) (
   input  logic        clk_mac,
   input  logic        rst_n,
   input  logic        rx_vld,
   input  logic        rx_sof,
   input  logic        rx_eof,
   input  logic        rx_err,
   input  logic [7:0]  rx_dat,
   input  logic [10:0] rx_len,
   output logic        m_vld,
   input  logic        m_rdy,
   output logic [7:0]  m_dat,
   output logic        m_sof,
   output logic        m_eof,
   output logic [10:0] m_len,
   output logic [15:0] drop_cnt,
   output logic [1:0]  wr_state_dbg,
   output logic [1:0]  rd_state_dbg
);

   localparam int PW = ADDR_W + 1;
   localparam logic [ADDR_W:0] BUF_BYTES = {1'b1, {ADDR_W{1'b0}}};
   localparam logic [ADDR_W:0] PTR_ONE   = {{ADDR_W{1'b0}}, 1'b1};

   // ---------------- write side ----------------
   logic [1:0]        wr_state, wr_state_n;
   logic [ADDR_W:0]   wr_ptr, wr_ptr_n;
   logic [ADDR_W:0]   commit_ptr, commit_ptr_n;
   logic [ADDR_W:0]   rd_ptr;
   logic [ADDR_W:0]   wr_used, commit_used;
   logic [10:0]       payload_len;
   logic              data_beat, eof_beat;
   logic              drop_inc;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_waddr;
   logic              fifo_push, fifo_pop, fifo_full, fifo_empty;
   logic [10:0]       fifo_dout;

   assign data_beat   = rx_vld && !rx_eof;
   assign eof_beat    = rx_vld && rx_eof;
   assign payload_len = rx_len - 11'(FCS_LEN);
   assign wr_used     = wr_ptr - rd_ptr;
   assign commit_used = commit_ptr - rd_ptr;

   always_comb begin
      wr_state_n   = wr_state;
      wr_ptr_n     = wr_ptr;
      commit_ptr_n = commit_ptr;
      drop_inc     = 1'b0;
      mem_we       = 1'b0;
      mem_waddr    = wr_ptr[ADDR_W-1:0];
      fifo_push    = 1'b0;
      case (wr_state)
         WR_IDLE: begin
            if (data_beat && rx_sof) begin
               if (commit_used == BUF_BYTES) begin
                  wr_state_n = WR_DROP;
               end else begin
                  mem_we     = 1'b1;
                  mem_waddr  = commit_ptr[ADDR_W-1:0];
                  wr_ptr_n   = commit_ptr + PTR_ONE;
                  wr_state_n = WR_FRAME;
               end
            end
         end
         WR_FRAME: begin
            if (data_beat && rx_sof) begin
               // New frame before the old one ended: old frame is lost,
               // the new one restarts at the last commit point.
               drop_inc = 1'b1;
               if (commit_used == BUF_BYTES) begin
                  wr_ptr_n   = commit_ptr;
                  wr_state_n = WR_DROP;
               end else begin
                  mem_we    = 1'b1;
                  mem_waddr = commit_ptr[ADDR_W-1:0];
                  wr_ptr_n  = commit_ptr + PTR_ONE;
               end
            end else if (data_beat) begin
               if (wr_used == BUF_BYTES) begin
                  wr_ptr_n   = commit_ptr;
                  wr_state_n = WR_DROP;
               end else begin
                  mem_we   = 1'b1;
                  wr_ptr_n = wr_ptr + PTR_ONE;
               end
            end else if (eof_beat) begin
               wr_state_n = WR_IDLE;
               if (!rx_err && len_ok(rx_len) && !fifo_full) begin
                  // Advance by payload only so the FCS bytes get overwritten.
                  fifo_push    = 1'b1;
                  commit_ptr_n = commit_ptr + PW'(payload_len);
                  wr_ptr_n     = commit_ptr + PW'(payload_len);
               end else begin
                  wr_ptr_n = commit_ptr;
                  drop_inc = 1'b1;
               end
            end
         end
         WR_DROP: begin
            if (eof_beat) begin
               drop_inc   = 1'b1;
               wr_state_n = WR_IDLE;
            end
         end
         default: wr_state_n = WR_IDLE;
      endcase
   end

   always_ff @(posedge clk_mac) begin
      if (!rst_n) begin
         wr_state   <= WR_IDLE;
         wr_ptr     <= '0;
         commit_ptr <= '0;
         drop_cnt   <= '0;
      end else begin
         wr_state   <= wr_state_n;
         wr_ptr     <= wr_ptr_n;
         commit_ptr <= commit_ptr_n;
         if (drop_inc) drop_cnt <= sat_inc16(drop_cnt);
      end
   end

   eth_len_fifo #(
      .W       (LEN_W),
      .DEPTH_W (DESC_DEPTH_W)
   ) u_len_fifo (
      .clk_mac (clk_mac),
      .rst_n   (rst_n),
      .push    (fifo_push),
      .din     (payload_len),
      .pop     (fifo_pop),
      .dout    (fifo_dout),
      .full    (fifo_full),
      .empty   (fifo_empty)
   );

   // ---------------- read side ----------------
   // mem_q always runs one byte ahead of m_dat, so an accepted byte can be
   // replaced the very next cycle without a bubble.
   logic [1:0]        rd_state;
   logic [10:0]       rd_cnt;
   logic              fire;
   logic              mem_re;
   logic [ADDR_W-1:0] mem_raddr;
   logic [7:0]        mem_q;

   assign fire     = m_vld && m_rdy;
   assign fifo_pop = (rd_state == RD_IDLE) && !fifo_empty;

   always_comb begin
      mem_re    = 1'b0;
      mem_raddr = rd_ptr[ADDR_W-1:0];
      case (rd_state)
         RD_IDLE: begin
            mem_re    = !fifo_empty;
            mem_raddr = rd_ptr[ADDR_W-1:0];
         end
         RD_PRIME: begin
            mem_re    = 1'b1;
            mem_raddr = rd_ptr[ADDR_W-1:0] + ADDR_W'(1);
         end
         RD_STREAM: begin
            mem_re    = fire && !m_eof;
            mem_raddr = rd_ptr[ADDR_W-1:0] + ADDR_W'(2);
         end
         default: mem_re = 1'b0;
      endcase
   end

   always_ff @(posedge clk_mac) begin
      if (!rst_n) begin
         rd_state <= RD_IDLE;
         rd_ptr   <= '0;
         rd_cnt   <= '0;
         m_vld    <= 1'b0;
         m_sof    <= 1'b0;
         m_eof    <= 1'b0;
         m_dat    <= '0;
         m_len    <= '0;
      end else begin
         case (rd_state)
            RD_IDLE: begin
               if (!fifo_empty) begin
                  m_len    <= fifo_dout;
                  rd_state <= RD_PRIME;
               end
            end
            RD_PRIME: begin
               m_vld    <= 1'b1;
               m_sof    <= 1'b1;
               m_dat    <= mem_q;
               m_eof    <= (m_len == 11'd1);
               rd_cnt   <= 11'd1;
               rd_state <= RD_STREAM;
            end
            RD_STREAM: begin
               if (fire) begin
                  rd_ptr <= rd_ptr + PTR_ONE;
                  if (m_eof) begin
                     m_vld    <= 1'b0;
                     m_sof    <= 1'b0;
                     m_eof    <= 1'b0;
                     rd_state <= RD_IDLE;
                  end else begin
                     m_dat  <= mem_q;
                     m_sof  <= 1'b0;
                     m_eof  <= ((rd_cnt + 11'd1) == m_len);
                     rd_cnt <= rd_cnt + 11'd1;
                  end
               end
            end
            default: rd_state <= RD_IDLE;
         endcase
      end
   end

   // ---------------- byte storage ----------------
   logic [7:0] buf_mem [0:(1<<ADDR_W)-1];

   always_ff @(posedge clk_mac) begin
      if (mem_we) buf_mem[mem_waddr] <= rx_dat;
      if (mem_re) mem_q <= buf_mem[mem_raddr];
   end

   assign wr_state_dbg = wr_state;
   assign rd_state_dbg = rd_state;

endmodule

// File: tb/tb_eth_rx_frame_buf.sv
module tb_eth_rx_frame_buf;
   import eth_pkg::*;

   // ---------------- clock / reset ----------------
   logic        clk_mac = 1'b0;
   logic        rst_n   = 1'b0;
   always #5 clk_mac = ~clk_mac;

   logic        rx_vld = 1'b0, rx_sof = 1'b0, rx_eof = 1'b0, rx_err = 1'b0;
   logic [7:0]  rx_dat = '0;
   logic [10:0] rx_len = '0;
   logic        m_vld, m_sof, m_eof;
   logic        m_rdy = 1'b0;
   logic [7:0]  m_dat;
   logic [10:0] m_len;
   logic [15:0] drop_cnt;
   logic [1:0]  wr_state_dbg, rd_state_dbg;

   eth_rx_frame_buf dut (
      .clk_mac      (clk_mac),
      .rst_n        (rst_n),
      .rx_vld       (rx_vld),
      .rx_sof       (rx_sof),
      .rx_eof       (rx_eof),
      .rx_err       (rx_err),
      .rx_dat       (rx_dat),
      .rx_len       (rx_len),
      .m_vld        (m_vld),
      .m_rdy        (m_rdy),
      .m_dat        (m_dat),
      .m_sof        (m_sof),
      .m_eof        (m_eof),
      .m_len        (m_len),
      .drop_cnt     (drop_cnt),
      .wr_state_dbg (wr_state_dbg),
      .rd_state_dbg (rd_state_dbg)
   );

   // ---------------- scoreboard state ----------------
   // Each entry: {byte, sof, eof, len}
   logic [20:0] exp_q[$];
   int n_checks  = 0;
   int n_fail    = 0;
   int exp_drop  = 0;
   int rdy_mode  = 1;     // 0: m_rdy low, 1: high, 2: toggle every cycle
   bit gap_chk   = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // ---------------- drivers ----------------
   initial forever begin
      @(posedge clk_mac); #1;
      case (rdy_mode)
         0:       m_rdy = 1'b0;
         1:       m_rdy = 1'b1;
         default: m_rdy = ~m_rdy;
      endcase
   end

   task automatic beat(input bit vld, input bit sof, input bit eof, input bit err,
                       input logic [7:0] dat, input logic [10:0] len);
      @(posedge clk_mac); #1;
      rx_vld = vld; rx_sof = sof; rx_eof = eof; rx_err = err;
      rx_dat = dat; rx_len = len;
   endtask

   task automatic rx_idle(input int n);
      for (int i = 0; i < n; i++) beat(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 11'd0);
   endtask

   task automatic send_frame(input int nbytes, input int len, input bit err, input bit commit);
      logic [7:0] pl[$];
      logic [7:0] b;
      for (int i = 0; i < nbytes; i++) begin
         if ($urandom_range(0, 7) == 0) rx_idle(1);
         b = 8'($urandom_range(0, 255));
         beat(1'b1, i == 0, 1'b0, 1'b0, b, 11'(i + 1));
         if (i < len - FCS_LEN) pl.push_back(b);
      end
      beat(1'b1, 1'b0, 1'b1, err, 8'h00, 11'(len));
      if (commit) begin
         for (int i = 0; i < pl.size(); i++)
            exp_q.push_back({pl[i], i == 0, i == pl.size() - 1, 11'(len - FCS_LEN)});
      end else begin
         exp_drop++;
      end
      rx_idle(1);
   endtask

   task automatic wait_drain(input int budget);
      int c = 0;
      while ((exp_q.size() != 0 || m_vld) && c < budget) begin
         @(posedge clk_mac);
         c++;
      end
      n_checks++;
      if (c >= budget) begin
         n_fail++;
         $display("FAIL drain_timeout: %0d bytes still expected after %0d cycles", exp_q.size(), budget);
      end
      rx_idle(4);
   endtask

   // ---------------- monitor ----------------
   logic [20:0] prev_out;
   logic [20:0] cur;
   logic [20:0] e;
   bit prev_stall = 1'b0, prev_acc = 1'b0, in_frame = 1'b0, gap_on = 1'b0;
   int gap = 0;

   initial forever begin
      @(negedge clk_mac);
      if (!rst_n) begin
         prev_stall = 1'b0; prev_acc = 1'b0; in_frame = 1'b0; gap_on = 1'b0;
      end else begin
         cur = {m_dat, m_sof, m_eof, m_len};
         if (prev_stall) check("hold_stable", {m_vld, cur}, {1'b1, prev_out});
         if (in_frame && prev_acc) check("no_bubble_vld", 32'(m_vld), 32'd1);
         if (gap_on) begin
            if (m_vld) begin
               n_checks++;
               if (gap > 2) begin
                  n_fail++;
                  $display("FAIL frame_gap: got %0d idle cycles, expected at most 2", gap);
               end
               gap_on = 1'b0;
            end else begin
               gap++;
            end
         end
         if (m_vld && m_rdy) begin
            if (exp_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL unexpected_out: got %h, expected no output", cur);
            end else begin
               e = exp_q.pop_front();
               check("out_byte", 32'(cur), 32'(e));
            end
            in_frame = !m_eof;
            if (m_eof && gap_chk && exp_q.size() > 0) begin
               gap_on = 1'b1;
               gap    = 0;
            end
         end
         prev_stall = m_vld && !m_rdy;
         prev_acc   = m_vld && m_rdy;
         prev_out   = cur;
      end
   end

   initial begin
      #900000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   // ---------------- test sequence ----------------
   typedef struct {
      int nbytes;
      int len;
      bit err;
      bit commit;
   } vec_t;

   vec_t vecs[9];

   initial begin
      vecs[0] = '{100,  100,  1'b0, 1'b1};   // nominal good frame
      vecs[1] = '{100,  100,  1'b1, 1'b0};   // receive error
      vecs[2] = '{100,  100,  1'b0, 1'b1};   // good frame after error
      vecs[3] = '{60,   60,   1'b0, 1'b0};   // runt
      vecs[4] = '{1523, 1523, 1'b0, 1'b0};   // one byte oversize
      vecs[5] = '{64,   64,   1'b0, 1'b1};   // minimum
      vecs[6] = '{1522, 1522, 1'b0, 1'b1};   // maximum
      vecs[7] = '{63,   63,   1'b0, 1'b0};   // one byte short
      vecs[8] = '{65,   65,   1'b0, 1'b1};

      // reset state
      repeat (3) @(posedge clk_mac);
      #1;
      check("rst_m_vld", 32'(m_vld), 32'd0);
      check("rst_m_sof", 32'(m_sof), 32'd0);
      check("rst_m_eof", 32'(m_eof), 32'd0);
      check("rst_m_dat", 32'(m_dat), 32'd0);
      check("rst_m_len", 32'(m_len), 32'd0);
      check("rst_drop_cnt", 32'(drop_cnt), 32'd0);
      check("rst_wr_state", 32'(wr_state_dbg), 32'(WR_IDLE));
      check("rst_rd_state", 32'(rd_state_dbg), 32'(RD_IDLE));
      @(posedge clk_mac); #1;
      rst_n = 1'b1;
      rx_idle(3);
      check("post_rst_m_vld", 32'(m_vld), 32'd0);

      // table-driven frames, output always ready
      rdy_mode = 1;
      for (int v = 0; v < 9; v++) begin
         send_frame(vecs[v].nbytes, vecs[v].len, vecs[v].err, vecs[v].commit);
         wait_drain(4000);
         check($sformatf("drop_cnt_vec%0d", v), 32'(drop_cnt), 32'(exp_drop));
      end

      // end beat with no frame in progress is ignored
      beat(1'b1, 1'b0, 1'b1, 1'b1, 8'h00, 11'd0);
      rx_idle(3);
      check("idle_eof_drop_cnt", 32'(drop_cnt), 32'(exp_drop));

      // start-of-frame in the middle of a frame abandons it
      beat(1'b1, 1'b1, 1'b0, 1'b0, 8'hAA, 11'd1);
      for (int i = 1; i < 40; i++) beat(1'b1, 1'b0, 1'b0, 1'b0, 8'(i), 11'(i + 1));
      exp_drop++;
      send_frame(100, 100, 1'b0, 1'b1);
      wait_drain(2000);
      check("sof_restart_drop_cnt", 32'(drop_cnt), 32'(exp_drop));

      // overflow: 5000 bytes into a stalled 4096-byte buffer
      rdy_mode = 0;
      rx_idle(2);
      for (int f = 0; f < 5; f++)
         send_frame(1000, 1000, 1'b0, (exp_q.size() + 1000) <= 4096);
      rx_idle(4);
      check("overflow_drop_cnt", 32'(drop_cnt), 32'(exp_drop));
      check("overflow_stalled_vld", 32'(m_vld), 32'd1);
      gap_chk  = 1'b1;
      rdy_mode = 1;
      wait_drain(8000);
      gap_chk  = 1'b0;

      // ready toggling every cycle
      rdy_mode = 2;
      send_frame(80, 80, 1'b0, 1'b1);
      send_frame(70, 70, 1'b0, 1'b1);
      wait_drain(2000);
      rdy_mode = 1;
      rx_idle(2);

      // reset mid-frame with two frames buffered
      rdy_mode = 0;
      rx_idle(2);
      send_frame(100, 100, 1'b0, 1'b1);
      send_frame(100, 100, 1'b0, 1'b1);
      beat(1'b1, 1'b1, 1'b0, 1'b0, 8'h55, 11'd1);
      for (int i = 1; i < 30; i++) beat(1'b1, 1'b0, 1'b0, 1'b0, 8'(i), 11'(i + 1));
      @(posedge clk_mac); #1;
      rst_n  = 1'b0;
      rx_vld = 1'b0; rx_sof = 1'b0; rx_eof = 1'b0; rx_err = 1'b0;
      exp_q.delete();
      exp_drop = 0;
      @(posedge clk_mac); #1;
      check("midrst_m_vld", 32'(m_vld), 32'd0);
      check("midrst_drop_cnt", 32'(drop_cnt), 32'd0);
      check("midrst_wr_state", 32'(wr_state_dbg), 32'(WR_IDLE));
      rst_n = 1'b1;
      rdy_mode = 1;
      rx_idle(30);
      check("midrst_buffer_empty", 32'(m_vld), 32'd0);
      send_frame(100, 100, 1'b0, 1'b1);
      wait_drain(2000);
      check("midrst_final_drop_cnt", 32'(drop_cnt), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
